// File: rtl/h264_pkg.sv
// h264_pkg: shared constants, FSM states and sizing helper for the H.264 bit packer
package h264_pkg;
  localparam logic [7:0] EP_BYTE = 8'h03;
  typedef enum logic [1:0] {PK_RUN, PK_PAD, PK_DRAIN, PK_DONE} pk_state_t;
  function automatic int accw(input int maxw);
    return maxw + 8;
  endfunction
endpackage

// File: rtl/h264_emul_prevent.sv
// h264_emul_prevent: byte-stream stage that inserts 0x03 after two 0x00 bytes when the next byte is <= 0x03
// ports: clk, rst_n | in_valid/in_ready/in_byte from packer | out_ready in, strobe/out_byte out
module h264_emul_prevent import h264_pkg::*; #(
  parameter int EP_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       out_ready,
  output logic       strobe,
  output logic [7:0] out_byte
);
  logic [1:0] zr_q, zr_d;
  logic       ins;
  // the inserted 0x03 is shown in place of in_byte, which is held back until the next cycle
  always_comb begin
    ins      = (EP_EN != 0) && zr_q == 2'd2 && in_valid && in_byte <= EP_BYTE;
    strobe   = in_valid;
    out_byte = ins ? EP_BYTE : in_byte;
    in_ready = out_ready && !ins;
    zr_d     = zr_q;
    if ((EP_EN != 0) && in_valid && out_ready)
      zr_d = (!ins && in_byte == 8'h00) ? (zr_q == 2'd2 ? 2'd2 : zr_q + 2'd1) : 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) zr_q <= 2'd0;
    else        zr_q <= zr_d;
endmodule

// File: rtl/h264_bitpacker.sv
// h264_bitpacker: packs MSB-first VLC codewords into a byte stream with flush, trailing bits and emulation prevention
// ports: clk, rst_n | valid/ready/ve/vl codeword input | flush in, done pulse out
//        out_ready in, strobe/byte_out byte output
module h264_bitpacker import h264_pkg::*; #(
  parameter int MAXW  = 25,
  parameter int LW    = 5,
  parameter int EP_EN = 1,
  parameter int TRAIL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  output logic            ready,
  input  logic [MAXW-1:0] ve,
  input  logic [LW-1:0]   vl,
  input  logic            flush,
  input  logic            out_ready,
  output logic            strobe,
  output logic [7:0]      byte_out,
  output logic            done
);
  localparam int ACCW   = accw(MAXW);
  localparam int CW     = $clog2(ACCW + 8);
  localparam int PADMAX = ACCW / 8 * 8;
  pk_state_t       state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d, acc_sh, code;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_sh, cnt_tr;
  logic [LW-1:0]   vl_s;
  logic [MAXW-1:0] ve_m;
  logic            bv, br, pop, pad_ok;
  h264_emul_prevent #(.EP_EN(EP_EN)) u_ep (
    .clk(clk), .rst_n(rst_n), .in_valid(bv), .in_ready(br), .in_byte(acc_q[ACCW-1 -: 8]),
    .out_ready(out_ready), .strobe(strobe), .out_byte(byte_out)
  );
  // acc_q is MSB-aligned and every bit below cnt_q is kept zero, so new bits can simply be OR-ed in
  always_comb begin
    bv     = cnt_q >= CW'(8);
    pop    = bv && br;
    acc_sh = pop ? acc_q << 8 : acc_q;
    cnt_sh = pop ? cnt_q - CW'(8) : cnt_q;
    ready  = state_q == PK_RUN && cnt_sh <= CW'(8);
    vl_s   = vl > LW'(MAXW) ? LW'(MAXW) : vl;
    ve_m   = ve & ~({MAXW{1'b1}} << vl_s);
    code   = ({ve_m, 8'h00} << (LW'(MAXW) - vl_s)) >> cnt_sh;
    cnt_tr = (cnt_sh + CW'(TRAIL) + CW'(7)) & ~CW'(7);
    // a full accumulator stalled by out_ready has no room for the stop bit yet
    pad_ok = cnt_sh + CW'(TRAIL) <= CW'(PADMAX);
    done   = state_q == PK_DONE;
    state_d = state_q;
    acc_d   = acc_sh;
    cnt_d   = cnt_sh;
    if (state_q == PK_RUN) begin
      if (valid && ready) begin
        acc_d = acc_sh | code;
        cnt_d = cnt_sh + CW'(vl_s);
      end
      if (flush) state_d = PK_PAD;
    end else if (state_q == PK_PAD) begin
      if (pad_ok) begin
        acc_d   = acc_sh | (TRAIL != 0 ? {1'b1, {(ACCW-1){1'b0}}} >> cnt_sh : '0);
        cnt_d   = cnt_tr;
        state_d = PK_DRAIN;
      end
    end else if (state_q == PK_DRAIN) begin
      if (cnt_sh == '0) state_d = PK_DONE;
    end else begin
      state_d = PK_RUN;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= PK_RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_h264_bitpacker.sv
// tb_h264_bitpacker: directed table-driven bench for h264_bitpacker with EP/TRAIL variants
module tb_h264_bitpacker;
  typedef struct {
    logic        v;
    logic [24:0] ve;
    logic [4:0]  vl;
    logic        fl;
    logic        s;
    logic [7:0]  b;
    logic        r;
    logic        d;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [24:0] ve = '0;
  logic [4:0]  vl = '0;
  logic r_m, s_m, d_m, r_b, s_b, d_b, r_t, s_t, d_t;
  logic [7:0] b_m, b_b, b_t;
  logic [7:0] q_m[$], q_b[$], q_t[$];
  int dn_m = 0, dn_b = 0, dn_t = 0;
  int checks = 0, failures = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  h264_bitpacker u_m (.clk(clk), .rst_n(rst_n), .valid(valid), .ready(r_m), .ve(ve), .vl(vl),
    .flush(flush), .out_ready(out_ready), .strobe(s_m), .byte_out(b_m), .done(d_m));
  h264_bitpacker #(.EP_EN(0), .TRAIL(1)) u_b (.clk(clk), .rst_n(rst_n), .valid(valid), .ready(r_b),
    .ve(ve), .vl(vl), .flush(flush), .out_ready(out_ready), .strobe(s_b), .byte_out(b_b), .done(d_b));
  h264_bitpacker #(.EP_EN(1), .TRAIL(0)) u_t (.clk(clk), .rst_n(rst_n), .valid(valid), .ready(r_t),
    .ve(ve), .vl(vl), .flush(flush), .out_ready(out_ready), .strobe(s_t), .byte_out(b_t), .done(d_t));
  always @(negedge clk) begin
    if (s_m && out_ready) q_m.push_back(b_m);
    if (s_b && out_ready) q_b.push_back(b_b);
    if (s_t && out_ready) q_t.push_back(b_t);
    if (d_m) dn_m++;
    if (d_b) dn_b++;
    if (d_t) dn_t++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_q(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk($sformatf("%s_%0d", nm, i), got[i], exp[i]);
  endtask
  task automatic step(input logic v, input logic [24:0] e, input logic [4:0] l, input logic f);
    @(posedge clk);
    #1;
    valid = v; ve = e; vl = l; flush = f;
  endtask
  task automatic wait_done(input int tgt);
    int n = 0;
    while ((dn_m < tgt || dn_b < tgt || dn_t < tgt) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("done_m", dn_m, tgt);
    chk("done_b", dn_b, tgt);
    chk("done_t", dn_t, tgt);
  endtask
  task automatic clr();
    q_m.delete(); q_b.delete(); q_t.delete();
  endtask
  function automatic vec_t mk(input logic v, input logic [24:0] e, input logic [4:0] l, input logic f,
                              input logic s, input logic [7:0] b, input logic r, input logic d);
    vec_t x;
    x.v = v; x.ve = e; x.vl = l; x.fl = f; x.s = s; x.b = b; x.r = r; x.d = d;
    return x;
  endfunction
  initial begin
    tv.push_back(mk(1, 25'd56789, 25, 0, 0, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h6E, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'hEA, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'hC0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0));
    for (int i = 0; i < 8; i++) tv.push_back(mk(1, 25'(i % 2 == 0), 1, 0, 0, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'hAA, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0));
    tv.push_back(mk(1, 25'h000001, 24, 0, 0, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h03, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h01, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", r_m, 1);
    chk("rst_strobe", s_m, 0);
    chk("rst_byte", b_m, 8'h00);
    chk("rst_done", d_m, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].v, tv[i].ve, tv[i].vl, tv[i].fl);
      @(negedge clk);
      chk($sformatf("row%0d_strobe", i), s_m, tv[i].s);
      if (tv[i].s) chk($sformatf("row%0d_byte", i), b_m, tv[i].b);
      chk($sformatf("row%0d_ready", i), r_m, tv[i].r);
      chk($sformatf("row%0d_done", i), d_m, tv[i].d);
    end
    step(0, 0, 0, 0);
    wait_done(2);
    chk_q("tbl_m", q_m, '{8'h00, 8'h6E, 8'hEA, 8'hC0, 8'hAA, 8'h00, 8'h00, 8'h03, 8'h01, 8'h80});
    chk_q("tbl_b", q_b, '{8'h00, 8'h6E, 8'hEA, 8'hC0, 8'hAA, 8'h00, 8'h00, 8'h01, 8'h80});
    chk_q("tbl_t", q_t, '{8'h00, 8'h6E, 8'hEA, 8'h80, 8'hAA, 8'h00, 8'h00, 8'h03, 8'h01});
    clr();
    out_ready = 1'b0;
    step(1, 25'd56789, 25, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("stall%0d_strobe", i), s_m, 1);
      chk($sformatf("stall%0d_byte", i), b_m, 8'h00);
      chk($sformatf("stall%0d_ready", i), r_m, 0);
    end
    step(0, 0, 0, 1);
    out_ready = 1'b1;
    step(0, 0, 0, 0);
    wait_done(3);
    chk_q("bp_m", q_m, '{8'h00, 8'h6E, 8'hEA, 8'hC0});
    chk_q("bp_b", q_b, '{8'h00, 8'h6E, 8'hEA, 8'hC0});
    chk_q("bp_t", q_t, '{8'h00, 8'h6E, 8'hEA, 8'h80});
    clr();
    repeat (3) step(1, 25'h1FFFFFF, 0, 0);
    @(negedge clk);
    chk("vl0_strobe", s_m, 0);
    chk("vl0_ready", r_m, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    wait_done(4);
    chk_q("fl0_m", q_m, '{8'h80});
    chk_q("fl0_b", q_b, '{8'h80});
    chk("fl0_t_len", q_t.size(), 0);
    clr();
    step(1, 25'h1FFFFFF, 31, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    wait_done(5);
    chk_q("sat_m", q_m, '{8'hFF, 8'hFF, 8'hFF, 8'hC0});
    chk_q("sat_b", q_b, '{8'hFF, 8'hFF, 8'hFF, 8'hC0});
    chk_q("sat_t", q_t, '{8'hFF, 8'hFF, 8'hFF, 8'h80});
    step(1, 25'h16, 5, 0);
    step(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", r_m, 1);
    chk("arst_strobe", s_m, 0);
    chk("arst_byte", b_m, 8'h00);
    chk("arst_done", d_m, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    step(1, 25'h5A, 8, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_strobe", s_m, 1);
    chk("post_rst_byte", b_m, 8'h5A);
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    chk_q("post_rst_m", q_m, '{8'h5A});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
